// File: rtl/pipeline_hazard_control.sv
// Pipeline hazard control: stall/flush/nop drive for IF/ID..MEM/WB,
// post-reset drain, memory-wait timeout and hazard counters.
module pipeline_hazard_control #(
  parameter int REG_BITS    = 5,
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_BITS-1:0]  id_rs,
  input  logic [REG_BITS-1:0]  id_rt,
  input  logic [REG_BITS-1:0]  ex_rt,
  input  logic                 ex_mem_to_reg,
  input  logic                 branch_mispredict,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic [3:0]           stall,
  output logic [3:0]           flush,
  output logic [3:0]           nop,
  output logic                 pc_stall,
  output logic                 mem_error,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events,
  output logic [CNT_WIDTH-1:0] load_use_events
);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_MEM_WAIT
  } state_t;

  localparam logic [3:0]  DRAIN_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT);

  state_t r_state;
  state_t w_next;
  logic [3:0]  r_drain;
  logic [3:0]  w_drain_nxt;
  logic [15:0] r_wait;
  logic [15:0] w_wait_nxt;
  logic        r_mem_error;
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [CNT_WIDTH-1:0] r_flush_events;
  logic [CNT_WIDTH-1:0] r_load_use_events;

  logic [3:0] w_stall;
  logic [3:0] w_flush;
  logic [3:0] w_nop;
  logic       w_pc_stall;
  logic       w_flush_evt;
  logic       w_lu_evt;
  logic       w_err_set;
  logic       w_load_use;

  // $0 is hardwired, so a load into it never creates a dependency
  assign w_load_use = ex_mem_to_reg
                    && (ex_rt != '0)
                    && ((ex_rt == id_rs) || (ex_rt == id_rt));

  // Next-state and pipeline-control decode for the current state
  always_comb begin
    w_next      = r_state;
    w_drain_nxt = r_drain;
    w_wait_nxt  = r_wait;
    w_stall     = 4'b0000;
    w_flush     = 4'b0000;
    w_nop       = 4'b0000;
    w_pc_stall  = 1'b0;
    w_flush_evt = 1'b0;
    w_lu_evt    = 1'b0;
    w_err_set   = 1'b0;
    unique case (r_state)
      S_INIT: begin
        w_nop       = 4'hF;
        w_flush     = 4'hF;
        w_pc_stall  = 1'b1;
        w_drain_nxt = r_drain + 4'd1;
        if (r_drain == DRAIN_LAST) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          w_stall    = 4'b0111;
          w_flush    = 4'b1000;
          w_pc_stall = 1'b1;
          w_wait_nxt = 16'd1;
          w_next     = S_MEM_WAIT;
        end else if (branch_mispredict) begin
          // PC loads the redirect target, so it is not held
          w_flush     = 4'b0011;
          w_flush_evt = 1'b1;
        end else if (w_load_use) begin
          w_stall    = 4'b0001;
          w_flush    = 4'b0010;
          w_pc_stall = 1'b1;
          w_lu_evt   = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready) begin
          w_wait_nxt = 16'd0;
          w_next     = S_RUN;
        end else if (r_wait == WAIT_LIMIT) begin
          // Give up on the access and let the pipeline move again
          w_err_set  = 1'b1;
          w_wait_nxt = 16'd0;
          w_next     = S_RUN;
        end else begin
          w_stall    = 4'b0111;
          w_flush    = 4'b1000;
          w_pc_stall = 1'b1;
          w_wait_nxt = r_wait + 16'd1;
        end
      end
      default: begin
        w_next = S_INIT;
      end
    endcase
  end

  // Reset forces the full hold/clear pattern without waiting for a clock
  always_comb begin
    stall    = w_stall;
    flush    = w_flush;
    nop      = w_nop;
    pc_stall = w_pc_stall;
    if (reset) begin
      stall    = 4'hF;
      flush    = 4'hF;
      nop      = 4'hF;
      pc_stall = 1'b1;
    end
  end

  // State, drain and wait counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      r_drain <= 4'd0;
      r_wait  <= 16'd0;
    end else begin
      r_state <= w_next;
      r_drain <= w_drain_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_error <= 1'b0;
    end else if (w_err_set) begin
      r_mem_error <= 1'b1;
    end
  end

  // Saturating hazard counters; drain cycles are not counted as stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles    <= '0;
      r_flush_events    <= '0;
      r_load_use_events <= '0;
    end else begin
      if (w_pc_stall && (r_state != S_INIT)
          && (r_stall_cycles != {CNT_WIDTH{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      end
      if (w_flush_evt && (r_flush_events != {CNT_WIDTH{1'b1}})) begin
        r_flush_events <= r_flush_events + CNT_WIDTH'(1);
      end
      if (w_lu_evt && (r_load_use_events != {CNT_WIDTH{1'b1}})) begin
        r_load_use_events <= r_load_use_events + CNT_WIDTH'(1);
      end
    end
  end

  assign mem_error       = r_mem_error;
  assign stall_cycles    = r_stall_cycles;
  assign flush_events    = r_flush_events;
  assign load_use_events = r_load_use_events;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Bench for pipeline_hazard_control: directed hazards plus random
// traffic, scored against a cycle-level behavioural model.
module tb_pipeline_hazard_control;

  localparam int RB   = 5;
  localparam int IC   = 4;
  localparam int TO   = 8;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [RB-1:0] id_rs;
  logic [RB-1:0] id_rt;
  logic [RB-1:0] ex_rt;
  logic          ex_mem_to_reg;
  logic          branch_mispredict;
  logic          mem_req;
  logic          mem_ready;
  logic [3:0]    stall;
  logic [3:0]    flush;
  logic [3:0]    nop;
  logic          pc_stall;
  logic          mem_error;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_events;
  logic [CW-1:0] load_use_events;

  pipeline_hazard_control #(
    .REG_BITS   (RB),
    .INIT_CYCLES(IC),
    .MEM_TIMEOUT(TO),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .ex_rt            (ex_rt),
    .ex_mem_to_reg    (ex_mem_to_reg),
    .branch_mispredict(branch_mispredict),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .stall            (stall),
    .flush            (flush),
    .nop              (nop),
    .pc_stall         (pc_stall),
    .mem_error        (mem_error),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events),
    .load_use_events  (load_use_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic [3:0] fl;
    logic [3:0] np;
    logic       pc;
    logic       err;
    int         sc;
    int         fe;
    int         lu;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Model: cycles of drain left, cycles spent waiting on memory
  int drain_left = 0;
  int wait_len   = 0;
  int m_sc = 0;
  int m_fe = 0;
  int m_lu = 0;
  bit m_err = 1'b0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic void model_step(output exp_t e);
    bit in_init;
    e.st = 4'h0;
    e.fl = 4'h0;
    e.np = 4'h0;
    e.pc = 1'b0;
    if (reset) begin
      drain_left = IC;
      wait_len   = 0;
      m_sc = 0;
      m_fe = 0;
      m_lu = 0;
      m_err = 1'b0;
      e.st = 4'hF;
      e.fl = 4'hF;
      e.np = 4'hF;
      e.pc = 1'b1;
      e.err = 1'b0;
      e.sc = 0;
      e.fe = 0;
      e.lu = 0;
      return;
    end
    e.sc  = m_sc;
    e.fe  = m_fe;
    e.lu  = m_lu;
    e.err = m_err;
    in_init = (drain_left > 0);
    if (in_init) begin
      e.fl = 4'hF;
      e.np = 4'hF;
      e.pc = 1'b1;
      drain_left--;
    end else if (wait_len > 0) begin
      if (mem_ready) begin
        wait_len = 0;
      end else if (wait_len >= TO) begin
        wait_len = 0;
        m_err = 1'b1;
      end else begin
        e.st = 4'b0111;
        e.fl = 4'b1000;
        e.pc = 1'b1;
        wait_len++;
      end
    end else if (mem_req && !mem_ready) begin
      e.st = 4'b0111;
      e.fl = 4'b1000;
      e.pc = 1'b1;
      wait_len = 1;
    end else if (branch_mispredict) begin
      e.fl = 4'b0011;
      if (m_fe < CMAX) m_fe++;
    end else if (ex_mem_to_reg && ex_rt != 0
                 && (ex_rt == id_rs || ex_rt == id_rt)) begin
      e.st = 4'b0001;
      e.fl = 4'b0010;
      e.pc = 1'b1;
      if (m_lu < CMAX) m_lu++;
    end
    if (e.pc && !in_init && m_sc < CMAX) m_sc++;
  endfunction

  task automatic drive(input bit r, input int rs, input int rt,
                       input int er, input bit m2r, input bit mis,
                       input bit req, input bit rdy);
    reset             = r;
    id_rs             = RB'(rs);
    id_rt             = RB'(rt);
    ex_rt             = RB'(er);
    ex_mem_to_reg     = m2r;
    branch_mispredict = mis;
    mem_req           = req;
    mem_ready         = rdy;
  endtask

  task automatic cyc(input bit r, input int rs, input int rt,
                     input int er, input bit m2r, input bit mis,
                     input bit req, input bit rdy);
    exp_t e;
    @(posedge clk);
    #1;
    drive(r, rs, rt, er, m2r, mis, req, rdy);
    model_step(e);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset raised mid-cycle must show up before any clock edge
  task automatic async_rst();
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("async_stall", 32'(stall), 32'hF);
    chk("async_flush", 32'(flush), 32'hF);
    chk("async_nop", 32'(nop), 32'hF);
    chk("async_pc_stall", 32'(pc_stall), 32'h1);
    chk("async_stall_cycles", 32'(stall_cycles), 32'h0);
    model_step(e);
    q.push_back(e);
  endtask

  // Monitor: compare every presented cycle against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", 32'(stall), 32'(e.st));
        chk("flush", 32'(flush), 32'(e.fl));
        chk("nop", 32'(nop), 32'(e.np));
        chk("pc_stall", 32'(pc_stall), 32'(e.pc));
        chk("mem_error", 32'(mem_error), 32'(e.err));
        chk("stall_cycles", 32'(stall_cycles), 32'(e.sc));
        chk("flush_events", 32'(flush_events), 32'(e.fe));
        chk("load_use_events", 32'(load_use_events), 32'(e.lu));
      end
    end
  end

  // Stimulus
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(IC + 2);
    // load-use on rs, then same pattern on $0
    cyc(0, 5, 9, 5, 1, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 7, 5, 5, 1, 0, 0, 0);
    // mispredict outranks a simultaneous load-use
    cyc(0, 3, 1, 3, 1, 1, 0, 0);
    idle(1);
    // three-cycle memory wait
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    // memory timeout, then error must persist
    for (int i = 0; i < TO + 1; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    cyc(0, 2, 2, 2, 1, 0, 0, 0);
    // reset during a memory wait
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    async_rst();
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    idle(IC + 2);
    // random traffic with small register indices to force matches
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) chk("scoreboard_drain", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_control.md
Name: pipeline_hazard_control

Overview:
- Control end of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Drives their stall, flush and nop inputs, and the PC write hold.
- Detects three hazards and resolves them:
  - load-use data hazards;
  - branch mispredicts resolved in EX;
  - multi-cycle data-memory waits.
- Runs a post-reset pipeline drain and keeps hazard performance counters.
- Sits beside the datapath top level. All outputs are valid in the same cycle so the registers sample them at the next posedge clk.

Parameters:
- REG_BITS, 5, register-index width; matches `NUM_REGISTERS_LOG2.
- INIT_CYCLES, 4, cycles of nop drain after reset release; must be 1..15.
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before mem_error is set; must be 1..65535.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_rs  in  REG_BITS  rs of the instruction in ID (IF/ID output decode)
- id_rt  in  REG_BITS  rt of the instruction in ID
- ex_rt  in  REG_BITS  rt of the instruction in EX (ID/EX output)
- ex_mem_to_reg  in  1  instruction in EX is a load
- branch_mispredict  in  1  EX resolved a branch against its prediction
- mem_req  in  1  instruction in MEM has mem_op != 0
- mem_ready  in  1  data memory completes the access this cycle
- stall  out  4  hold enables; bit0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB
- flush  out  4  clear enables, same bit order
- nop  out  4  output-mask enables, same bit order
- pc_stall  out  1  hold the PC
- mem_error  out  1  sticky memory-timeout flag
- stall_cycles  out  CNT_WIDTH  cycles with pc_stall=1 while in RUN or MEM_WAIT
- flush_events  out  CNT_WIDTH  mispredict flushes issued
- load_use_events  out  CNT_WIDTH  load-use bubbles issued

Behaviour:
- Register semantics this block relies on: flush beats stall inside each register; nop is latched and masks the outputs on the following cycle.

Reset state (held while reset is high):
- state=INIT, drain counter=0.
- stall=4'hF, flush=4'hF, nop=4'hF, pc_stall=1.
- mem_error=0, all counters=0.

INIT state:
- Outputs: nop=4'hF, flush=4'hF, stall=0, pc_stall=1.
- Drain counter increments each cycle; moves to RUN after INIT_CYCLES cycles.

RUN state, combinational outputs, evaluated in this priority order:
1. mem_req && !mem_ready: stall=4'b0111, flush=4'b1000, pc_stall=1. Enter MEM_WAIT next cycle; wait counter=1.
2. branch_mispredict: flush=4'b0011, stall=0, pc_stall=0 (PC loads the redirect). flush_events+1.
3. Load-use, i.e. ex_mem_to_reg && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt): stall=4'b0001, flush=4'b0010, pc_stall=1. load_use_events+1. The bubble clears ex_mem_to_reg, so the stall lasts exactly 1 cycle.
4. Otherwise: all outputs 0.
- In every RUN case, nop=0.

MEM_WAIT state:
- Outputs as in priority 1 while mem_ready=0. Mispredict and load-use are ignored; their inputs are held frozen by the upstream stall.
- When mem_ready=1: outputs all 0 that cycle and return to RUN. Pending mispredict/load-use is then evaluated in the following cycle.
- Wait counter increments each cycle. On reaching MEM_TIMEOUT: set mem_error (sticky until reset) and return to RUN, releasing the pipeline.

Counters:
- Saturate at all-ones; never wrap.
- stall_cycles increments on every cycle with pc_stall=1 while state != INIT.

Reset asserted mid-operation: immediately forces the reset state, regardless of current state or counters.

Index 0 never causes a load-use hazard (register $0).

Test Plan:
- Reset release with INIT_CYCLES=4 -> nop=flush=4'hF and pc_stall=1 for exactly 4 cycles; 5th cycle all outputs 0.
- Load-use: ex_mem_to_reg=1, ex_rt=5, id_rs=5 -> one cycle of stall=0001, flush=0010, pc_stall=1; load_use_events=1. Repeat with ex_rt=0 -> no stall.
- branch_mispredict pulse for 1 cycle with a simultaneous load-use match -> flush=0011, pc_stall=0; flush_events=1, load_use_events unchanged.
- mem_req=1, mem_ready low for 3 cycles then high -> stall=0111, flush=1000 for 3 cycles, then 0; stall_cycles=3; mem_error=0.
- MEM_TIMEOUT=8 with mem_ready held low -> release after 8 cycles; mem_error=1 and stays 1 until reset.
- reset asserted during MEM_WAIT -> outputs return to the reset values asynchronously; counters=0; state=INIT on release.
